// File: rtl/shift_sequencer_if.sv
// Command and result handshakes between a requester and shift_sequencer.
interface shift_sequencer_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic [CNT_W-1:0] cmd_count;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;

  modport master (
    output cmd_valid, cmd_op, cmd_data, cmd_count, res_ready,
    input  cmd_ready, res_valid, res_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, cmd_count, res_ready,
    output cmd_ready, res_valid, res_data
  );
endinterface

// File: rtl/shift_sequencer.sv
// Command-driven controller for a load/rotate/shift register: loads a value,
// applies count shift cycles in the requested direction, returns the result.
module shift_sequencer #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  shift_sequencer_if.slave cmd_if,
  output logic             busy,
  output logic             par_load_n,
  output logic             rotate_right,
  output logic             as_right,
  output logic [WIDTH-1:0] data_in,
  input  logic [WIDTH-1:0] reg_q
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;
  typedef enum logic [1:0] {OP_ROL = 2'b00, OP_ROR = 2'b01, OP_ASR = 2'b10, OP_LOAD = 2'b11} op_t;

  state_t           state;
  op_t              op_q;
  logic [WIDTH-1:0] data_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] rem;

  // Outside LOAD the register recirculates its own contents (hold rule).
  assign data_in         = (state == LOAD) ? data_q : reg_q;
  assign cmd_if.res_data = reg_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      op_q             <= OP_ROL;
      data_q           <= '0;
      cnt_q            <= '0;
      rem              <= '0;
      cmd_if.cmd_ready <= 1'b0;
      cmd_if.res_valid <= 1'b0;
      busy             <= 1'b0;
      par_load_n       <= 1'b0;
      rotate_right     <= 1'b0;
      as_right         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_if.cmd_valid && cmd_if.cmd_ready) begin
            op_q             <= op_t'(cmd_if.cmd_op);
            data_q           <= cmd_if.cmd_data;
            cnt_q            <= cmd_if.cmd_count;
            state            <= LOAD;
            cmd_if.cmd_ready <= 1'b0;
            busy             <= 1'b1;
            par_load_n       <= 1'b0;
            rotate_right     <= 1'b0;
            as_right         <= 1'b0;
          end else begin
            cmd_if.cmd_ready <= 1'b1;
          end
        end
        LOAD: begin
          if (op_q != OP_LOAD && cnt_q != '0) begin
            state        <= SHIFT;
            rem          <= cnt_q;
            par_load_n   <= 1'b1;
            rotate_right <= (op_q == OP_ROR) || (op_q == OP_ASR);
            as_right     <= (op_q == OP_ASR);
          end else begin
            state            <= DONE;
            busy             <= 1'b0;
            cmd_if.res_valid <= 1'b1;
          end
        end
        SHIFT: begin
          // Exit while rem==1 so the counter never wraps and exactly
          // cnt_q shift edges occur.
          if (rem == CNT_W'(1)) begin
            state            <= DONE;
            busy             <= 1'b0;
            cmd_if.res_valid <= 1'b1;
            par_load_n       <= 1'b0;
            rotate_right     <= 1'b0;
            as_right         <= 1'b0;
          end else begin
            rem <= rem - CNT_W'(1);
          end
        end
        DONE: begin
          if (cmd_if.res_ready) begin
            state            <= IDLE;
            cmd_if.res_valid <= 1'b0;
            cmd_if.cmd_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Randomized scoreboard bench for shift_sequencer driving a behavioural
// 4-bit load/rotate/shift register.
module tb_shift_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       busy, par_load_n, rotate_right, as_right;
  logic [3:0] data_in;
  logic [3:0] reg_q;

  shift_sequencer_if #(.WIDTH(4), .CNT_W(3)) bus ();

  shift_sequencer #(.WIDTH(4), .CNT_W(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_if       (bus),
    .busy         (busy),
    .par_load_n   (par_load_n),
    .rotate_right (rotate_right),
    .as_right     (as_right),
    .data_in      (data_in),
    .reg_q        (reg_q)
  );

  always #5 clk = ~clk;

  // The team's shift register.
  always @(posedge clk or posedge rst) begin
    if (rst)                reg_q <= 4'b0000;
    else if (!par_load_n)   reg_q <= data_in;
    else if (!rotate_right) reg_q <= {reg_q[2:0], reg_q[3]};
    else if (as_right)      reg_q <= {reg_q[3], reg_q[3:1]};
    else                    reg_q <= {reg_q[0], reg_q[3:1]};
  end

  typedef struct {
    int   data;
    int   shifts;
    logic rr;
    logic asr;
    int   acc_cyc;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   hs_cyc = -1;
  int   shift_cnt = 0;
  int   busy_cnt = 0;
  bit   in_res = 0;
  int   rdy_delay = 0;
  int   hold_cnt = 0;
  bit   pre_ready = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Reference: apply the operation n times using plain arithmetic on 0..15.
  function automatic int ref_model(input int op, input int d, input int n);
    int v = d;
    if (op != 3) begin
      for (int i = 0; i < n; i++) begin
        case (op)
          0:       v = (v * 2) % 16 + v / 8;
          1:       v = v / 2 + (v % 2) * 8;
          default: v = v / 2 + ((v >= 8) ? 8 : 0);
        endcase
      end
    end
    return v;
  endfunction

  // Result consumer: optional early ready, then ready after rdy_delay cycles.
  initial bus.res_ready = 1'b0;
  always @(posedge clk) begin
    #1;
    if (bus.res_valid) begin
      bus.res_ready = (hold_cnt >= rdy_delay);
      hold_cnt++;
    end else begin
      hold_cnt      = 0;
      bus.res_ready = pre_ready;
    end
  end

  // Monitor: pops the scoreboard when a result appears and checks it
  // for as long as it is presented.
  always @(negedge clk) begin
    if (rst) begin
      shift_cnt = 0;
      busy_cnt  = 0;
      in_res    = 0;
    end else begin
      if (busy) busy_cnt++;
      if (busy || bus.res_valid) chk("ready_low_when_busy", bus.cmd_ready, 0);
      if (bus.cmd_valid && bus.cmd_ready) chk("accept_after_idle", (cyc > hs_cyc) ? 1 : 0, 1);
      if (busy && par_load_n) begin
        shift_cnt++;
        if (sb.size() > 0) begin
          chk("rotate_right", rotate_right, sb[0].rr);
          chk("as_right", as_right, sb[0].asr);
        end
      end
      if (bus.res_valid) begin
        if (!in_res) begin
          if (sb.size() == 0) begin
            chk("spurious_result", 1, 0);
          end else begin
            cur    = sb.pop_front();
            in_res = 1;
            chk("latency", cyc - cur.acc_cyc, cur.shifts + 2);
            chk("shift_cycles", shift_cnt, cur.shifts);
            chk("busy_cycles", busy_cnt, cur.shifts + 1);
          end
        end
        if (in_res) begin
          chk("res_data", int'(bus.res_data), cur.data);
          chk("busy_in_done", busy, 0);
          chk("hold_load_in_done", par_load_n, 0);
        end
        if (bus.res_ready) begin
          in_res    = 0;
          shift_cnt = 0;
          busy_cnt  = 0;
          hs_cyc    = cyc;
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accept edge. A
  // following call raises cmd_valid again immediately, so commands are held.
  task automatic send(input int op, input int d, input int n, input int dly);
    bit   ok = 0;
    exp_t e;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'(op);
    bus.cmd_data  = 4'(d);
    bus.cmd_count = 3'(n);
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (bus.cmd_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      chk("accept_timeout", 0, 1);
    end else begin
      e.data    = ref_model(op % 4, d % 16, n % 8);
      e.shifts  = (op % 4 == 3) ? 0 : n % 8;
      e.rr      = (op % 4 == 1) || (op % 4 == 2);
      e.asr     = (op % 4 == 2);
      e.acc_cyc = cyc;
      sb.push_back(e);
      rdy_delay = dly;
    end
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'($urandom);
    bus.cmd_data  = 4'($urandom);
    bus.cmd_count = 3'($urandom);
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (sb.size() == 0 && !bus.res_valid && !busy) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("idle_timeout", 0, 1);
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
    bus.cmd_data  = 4'b0000;
    bus.cmd_count = 3'b000;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_cmd_ready", bus.cmd_ready, 0);
    chk("reset_res_valid", bus.res_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_par_load_n", par_load_n, 0);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    chk("ready_after_reset", bus.cmd_ready, 1);

    // Directed cases, then two ASR commands held back to back.
    send(1, 4'b1001, 2, 0);
    send(0, 4'b1001, 3, 5);
    send(3, 4'b1010, 5, 1);
    send(1, 4'b1001, 0, 0);
    send(2, 4'b1011, 7, 0);
    send(2, $urandom_range(0, 15), 7, 2);
    wait_idle();
    @(posedge clk);
    #1;

    // Asynchronous reset during the second SHIFT cycle.
    send(0, $urandom_range(0, 15), 5, 0);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("midshift_cmd_ready", bus.cmd_ready, 0);
    chk("midshift_res_valid", bus.res_valid, 0);
    chk("midshift_busy", busy, 0);
    chk("midshift_par_load_n", par_load_n, 0);
    chk("midshift_rotate_right", rotate_right, 0);
    sb.delete();
    @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;
    chk("ready_after_midshift_reset", bus.cmd_ready, 1);
    send(1, 4'b1001, 2, 0);
    wait_idle();
    @(posedge clk);
    #1;

    for (int i = 0; i < 30; i++) begin
      pre_ready = 1'($urandom);
      send($urandom_range(0, 3), $urandom_range(0, 15), $urandom_range(0, 7), $urandom_range(0, 3));
    end
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
